// File: rtl/mask_bbox_tracker_pkg.sv
//------------------------------------------------------------------------------
// Package : mask_tracker_pkg
// Shared widths, FSM state type and constants for mask_bbox_tracker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mask_tracker_pkg;

  localparam int MAX_WIDTH_DEF  = 640;
  localparam int MAX_HEIGHT_DEF = 480;

  localparam int XW      = $clog2(MAX_WIDTH_DEF);
  localparam int YW      = $clog2(MAX_HEIGHT_DEF);
  localparam int COUNT_W = XW + YW;

  // Minimum-tracking registers start here so the first hit always wins
  localparam logic [31:0] EMPTY_MIN = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACCUM      = 1'b1
  } state_t;

endpackage : mask_tracker_pkg

`default_nettype wire

// File: rtl/mask_bbox_tracker_if.sv
//------------------------------------------------------------------------------
// Interface : mask_bbox_tracker_if
// Pixel-mask input stream and frame-result valid/ready bundle.
// slave  = tracker side, master = pixel source / result consumer side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mask_bbox_tracker_if #(
  parameter int XW = mask_tracker_pkg::XW,
  parameter int YW = mask_tracker_pkg::YW
);

  logic              pixelValid;
  logic              maskBit;
  logic              newLine;
  logic              newFrame;
  logic              resultReady;
  logic              resultValid;
  logic              found;
  logic [XW-1:0]     minX;
  logic [XW-1:0]     maxX;
  logic [YW-1:0]     minY;
  logic [YW-1:0]     maxY;
  logic [XW+YW-1:0]  pixelCount;
  logic              overrun;
  logic [31:0]       sumX;
  logic [31:0]       sumY;

  modport slave (
    input  pixelValid, maskBit, newLine, newFrame, resultReady,
    output resultValid, found, minX, maxX, minY, maxY, pixelCount,
           overrun, sumX, sumY
  );

  modport master (
    output pixelValid, maskBit, newLine, newFrame, resultReady,
    input  resultValid, found, minX, maxX, minY, maxY, pixelCount,
           overrun, sumX, sumY
  );

endinterface : mask_bbox_tracker_if

`default_nettype wire

// File: rtl/mask_bbox_tracker_axis_extent.sv
//------------------------------------------------------------------------------
// Module  : mask_axis_extent
// Running min/max of one coordinate axis over the hits of a frame.
// init re-arms the pair; a hit coincident with init belongs to the new frame.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mask_axis_extent
  import mask_tracker_pkg::*;
#(
  parameter int W = 10
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  input  wire logic [W-1:0] coord_i,
  input  wire logic         hit_i,
  input  wire logic         init_i,
  output logic      [W-1:0] min_o,
  output logic      [W-1:0] max_o
);

  localparam logic [W-1:0] EMPTY = EMPTY_MIN[W-1:0];

  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  // Next extent: re-arm on init (seeded by a coincident hit), else widen on hit
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (init_i) begin
      min_d = hit_i ? coord_i : EMPTY;
      max_d = hit_i ? coord_i : '0;
    end else if (hit_i) begin
      if (coord_i < min_q) min_d = coord_i;
      if (coord_i > max_q) max_d = coord_i;
    end
  end

  // Extent registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= EMPTY;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule : mask_axis_extent

`default_nettype wire

// File: rtl/mask_bbox_tracker.sv
//------------------------------------------------------------------------------
// Module  : mask_bbox_tracker
// Reduces a per-pixel threshold mask, frame by frame, to a bounding box and a
// set-pixel count, handed out over a valid/ready handshake.
// Optional feature macro: MASK_CENTROID_EN (builds 32-bit centroid sums).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mask_bbox_tracker
  import mask_tracker_pkg::*;
#(
  parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
  parameter int MAX_HEIGHT = MAX_HEIGHT_DEF
) (
  input  wire logic          clock,
  input  wire logic          nReset,
  mask_bbox_tracker_if.slave bus
);

  localparam int PXW = $clog2(MAX_WIDTH);
  localparam int PYW = $clog2(MAX_HEIGHT);
  localparam int PCW = PXW + PYW;
  localparam logic [PXW-1:0] X_LAST = PXW'(MAX_WIDTH - 1);
  localparam logic [PYW-1:0] Y_LAST = PYW'(MAX_HEIGHT - 1);

  state_t           state_q;
  logic [PXW-1:0]   xPos_q, xPos_d, pixX;
  logic [PYW-1:0]   yPos_q, yPos_d, pixY;
  logic [PCW-1:0]   count_q;
  logic             any_q;
  logic             hit, publish;
  logic [PXW-1:0]   accMinX, accMaxX;
  logic [PYW-1:0]   accMinY, accMaxY;

  logic             resultValid_q, found_q, overrun_q;
  logic [PXW-1:0]   minX_q, maxX_q;
  logic [PYW-1:0]   minY_q, maxY_q;
  logic [PCW-1:0]   pixelCount_q;

  // Coordinate of the current pixel and the next scan position (saturating)
  always_comb begin
    pixX = (bus.newFrame || bus.newLine) ? '0 : xPos_q;
    if (bus.newFrame)     pixY = '0;
    else if (bus.newLine) pixY = (yPos_q == Y_LAST) ? yPos_q : yPos_q + 1'b1;
    else                  pixY = yPos_q;
    xPos_d = pixX;
    if (bus.pixelValid && (pixX != X_LAST)) xPos_d = pixX + 1'b1;
    yPos_d = pixY;
  end

  // A pixel coincident with newFrame is pixel 0 of the frame being opened
  assign hit     = bus.pixelValid && bus.maskBit && ((state_q == ACCUM) || bus.newFrame);
  assign publish = bus.newFrame && (state_q == ACCUM);

  mask_axis_extent #(.W(PXW)) u_ext_x (
    .clk_i(clock), .rst_ni(nReset), .coord_i(pixX), .hit_i(hit),
    .init_i(bus.newFrame), .min_o(accMinX), .max_o(accMaxX)
  );

  mask_axis_extent #(.W(PYW)) u_ext_y (
    .clk_i(clock), .rst_ni(nReset), .coord_i(pixY), .hit_i(hit),
    .init_i(bus.newFrame), .min_o(accMinY), .max_o(accMaxY)
  );

  // Scan position, saturating set-pixel count and any-hit flag
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      xPos_q  <= '0;
      yPos_q  <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
    end else begin
      xPos_q <= xPos_d;
      yPos_q <= yPos_d;
      if (bus.newFrame) begin
        count_q <= hit ? PCW'(1) : '0;
        any_q   <= hit;
      end else if (hit) begin
        if (count_q != '1) count_q <= count_q + 1'b1;
        any_q <= 1'b1;
      end
    end
  end

  // Frame FSM with registered result outputs and valid/ready/overrun tracking
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= WAIT_FRAME;
      resultValid_q <= 1'b0;
      found_q       <= 1'b0;
      overrun_q     <= 1'b0;
      minX_q        <= '0;
      maxX_q        <= '0;
      minY_q        <= '0;
      maxY_q        <= '0;
      pixelCount_q  <= '0;
    end else begin
      case (state_q)
        WAIT_FRAME: if (bus.newFrame) state_q <= ACCUM;
        default:    state_q <= ACCUM;
      endcase
      if (publish) begin
        resultValid_q <= 1'b1;
        found_q       <= any_q;
        minX_q        <= any_q ? accMinX : '0;
        maxX_q        <= any_q ? accMaxX : '0;
        minY_q        <= any_q ? accMinY : '0;
        maxY_q        <= any_q ? accMaxY : '0;
        pixelCount_q  <= any_q ? count_q : '0;
        if (resultValid_q && !bus.resultReady) overrun_q <= 1'b1;
      end else if (resultValid_q && bus.resultReady) begin
        resultValid_q <= 1'b0;
      end
    end
  end

`ifdef MASK_CENTROID_EN
  logic [31:0] accSumX_q, accSumY_q, sumX_q, sumY_q;

  // Centroid sums: accumulate per frame (wrapping), publish alongside the box
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      accSumX_q <= '0;
      accSumY_q <= '0;
      sumX_q    <= '0;
      sumY_q    <= '0;
    end else begin
      if (bus.newFrame) begin
        accSumX_q <= hit ? 32'(pixX) : '0;
        accSumY_q <= hit ? 32'(pixY) : '0;
      end else if (hit) begin
        accSumX_q <= accSumX_q + 32'(pixX);
        accSumY_q <= accSumY_q + 32'(pixY);
      end
      if (publish) begin
        sumX_q <= accSumX_q;
        sumY_q <= accSumY_q;
      end
    end
  end

  assign bus.sumX = sumX_q;
  assign bus.sumY = sumY_q;
`else
  assign bus.sumX = '0;
  assign bus.sumY = '0;
`endif

  assign bus.resultValid = resultValid_q;
  assign bus.found       = found_q;
  assign bus.overrun     = overrun_q;
  assign bus.minX        = minX_q;
  assign bus.maxX        = maxX_q;
  assign bus.minY        = minY_q;
  assign bus.maxY        = maxY_q;
  assign bus.pixelCount  = pixelCount_q;

endmodule : mask_bbox_tracker

`default_nettype wire

// File: tb/tb_mask_bbox_tracker.sv
//------------------------------------------------------------------------------
// Module  : tb_mask_bbox_tracker
// Directed self-checking bench for mask_bbox_tracker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mask_bbox_tracker;

`ifdef MASK_CENTROID_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic clock = 1'b0;
  logic nReset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mask_bbox_tracker_if bus ();

  mask_bbox_tracker dut (
    .clock (clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge with inputs idle
  task automatic px(input logic pv, input logic mb, input logic nl, input logic nf, input logic rr);
    bus.pixelValid  = pv;
    bus.maskBit     = mb;
    bus.newLine     = nl;
    bus.newFrame    = nf;
    bus.resultReady = rr;
    @(posedge clock);
    #1;
    bus.pixelValid  = 1'b0;
    bus.maskBit     = 1'b0;
    bus.newLine     = 1'b0;
    bus.newFrame    = 1'b0;
    bus.resultReady = 1'b0;
  endtask

  // n valid pixels on the current line, mask set only at index setx
  task automatic row(input int n, input int setx);
    for (int i = 0; i < n; i++) px(1'b1, (i == setx), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.pixelValid  = 1'b0;
    bus.maskBit     = 1'b0;
    bus.newLine     = 1'b0;
    bus.newFrame    = 1'b0;
    bus.resultReady = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(bus.resultValid), 0);
    chk("rst_found", 32'(bus.found), 0);
    chk("rst_maxX", 32'(bus.maxX), 0);
    chk("rst_count", 32'(bus.pixelCount), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    nReset = 1'b1;
    px(0, 0, 0, 0, 0);

    // 1: 4x3 frame, single hit at (2,1)
    px(0, 0, 0, 1, 0);
    chk("t1_open_novalid", 32'(bus.resultValid), 0);
    row(4, -1); px(0, 0, 1, 0, 0);
    row(4, 2);  px(0, 0, 1, 0, 0);
    row(4, -1);
    px(0, 0, 0, 1, 0);
    chk("t1_valid", 32'(bus.resultValid), 1);
    chk("t1_found", 32'(bus.found), 1);
    chk("t1_minX", 32'(bus.minX), 2);
    chk("t1_maxX", 32'(bus.maxX), 2);
    chk("t1_minY", 32'(bus.minY), 1);
    chk("t1_maxY", 32'(bus.maxY), 1);
    chk("t1_count", 32'(bus.pixelCount), 1);
    chk("t1_sumX", bus.sumX, CEN ? 32'd2 : 32'd0);
    chk("t1_sumY", bus.sumY, CEN ? 32'd1 : 32'd0);
    px(0, 0, 0, 0, 1);
    chk("t1_accept_valid", 32'(bus.resultValid), 0);
    chk("t1_overrun", 32'(bus.overrun), 0);

    // 2: empty 4x3 frame, then held without ready
    row(4, -1); px(0, 0, 1, 0, 0);
    row(4, -1); px(0, 0, 1, 0, 0);
    row(4, -1);
    px(0, 0, 0, 1, 0);
    chk("t2_valid", 32'(bus.resultValid), 1);
    chk("t2_found", 32'(bus.found), 0);
    chk("t2_minX", 32'(bus.minX), 0);
    chk("t2_minY", 32'(bus.minY), 0);
    chk("t2_maxY", 32'(bus.maxY), 0);
    chk("t2_count", 32'(bus.pixelCount), 0);
    px(0, 0, 0, 0, 0);
    chk("t2_hold_valid", 32'(bus.resultValid), 1);

    // Publish coincident with accept: no overrun
    row(4, 1);
    px(0, 0, 0, 1, 1);
    chk("tpa_valid", 32'(bus.resultValid), 1);
    chk("tpa_minX", 32'(bus.minX), 1);
    chk("tpa_count", 32'(bus.pixelCount), 1);
    chk("tpa_overrun", 32'(bus.overrun), 0);

    // 3: publish over an unaccepted result
    row(4, 3);
    px(0, 0, 0, 1, 0);
    chk("t3_valid", 32'(bus.resultValid), 1);
    chk("t3_overrun", 32'(bus.overrun), 1);
    chk("t3_minX", 32'(bus.minX), 3);
    px(0, 0, 0, 0, 0);
    chk("t3_stable_maxX", 32'(bus.maxX), 3);
    px(0, 0, 0, 0, 1);
    chk("t3_accept_valid", 32'(bus.resultValid), 0);
    chk("t3_overrun_sticky", 32'(bus.overrun), 1);

    // 4: newLine with a coincident set pixel at line 2
    px(1, 0, 0, 0, 0); px(1, 0, 0, 0, 0);
    px(1, 0, 1, 0, 0); px(1, 0, 0, 0, 0);
    px(1, 1, 1, 0, 0); px(1, 0, 0, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("t4_minX", 32'(bus.minX), 0);
    chk("t4_maxX", 32'(bus.maxX), 0);
    chk("t4_minY", 32'(bus.minY), 2);
    chk("t4_maxY", 32'(bus.maxY), 2);
    chk("t4_count", 32'(bus.pixelCount), 1);
    px(0, 0, 0, 0, 1);

    // 5: 700-pixel line, last pixel set -> X saturates at 639
    row(700, 699);
    px(0, 0, 0, 1, 0);
    chk("t5_maxX", 32'(bus.maxX), 639);
    chk("t5_minX", 32'(bus.minX), 639);
    chk("t5_count", 32'(bus.pixelCount), 1);
    px(0, 0, 0, 0, 1);

    // 6: asynchronous reset mid-frame discards the partial frame
    row(5, -1);
    for (int i = 0; i < 5; i++) px(1, 1, 0, 0, 0);
    #2 nReset = 1'b0;
    #2;
    chk("t6_rst_overrun", 32'(bus.overrun), 0);
    chk("t6_rst_maxX", 32'(bus.maxX), 0);
    chk("t6_rst_count", 32'(bus.pixelCount), 0);
    @(posedge clock);
    #1 nReset = 1'b1;
    px(0, 0, 0, 1, 0);
    chk("t6_open_novalid", 32'(bus.resultValid), 0);
    row(2, 1);
    px(0, 0, 0, 1, 0);
    chk("t6_valid", 32'(bus.resultValid), 1);
    chk("t6_count", 32'(bus.pixelCount), 1);
    chk("t6_minX", 32'(bus.minX), 1);
    chk("t6_maxX", 32'(bus.maxX), 1);
    chk("t6_minY", 32'(bus.minY), 0);
    chk("t6_maxY", 32'(bus.maxY), 0);
    chk("t6_overrun", 32'(bus.overrun), 0);
    chk("t6_sumX", bus.sumX, CEN ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mask_bbox_tracker

`default_nettype wire
